// File: rtl/regfile_write_arbiter.sv
// Single write-port arbiter: core writeback (priority) and FIFO-buffered USART words share one
// registered register-bank port. Optional REGFILE_ARB_ZERO_PROTECT_EN suppresses writes to register 0.
module regfile_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          core_wr_req,
  input  logic [ADDR_W-1:0]             core_wr_addr,
  input  logic [DATA_W-1:0]             core_wr_data,
  output logic                          core_stall,
  input  logic                          usart_valid,
  input  logic [ADDR_W-1:0]             usart_addr,
  input  logic [DATA_W-1:0]             usart_data,
  output logic                          usart_ready,
  output logic                          rf_wr_en,
  output logic [ADDR_W-1:0]             rf_wr_addr,
  output logic [DATA_W-1:0]             rf_wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(MAX_WAIT - 1);

  typedef enum logic {S_NORMAL, S_FORCE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ready_q, overflow_q;
  logic               rf_en_q;
  logic [ADDR_W-1:0]  rf_addr_q;
  logic [DATA_W-1:0]  rf_data_q;
  logic [ADDR_W-1:0]  mem_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_data_q [FIFO_DEPTH];

  logic               fifo_empty, push, pop;
  logic               core_gnt, usart_gnt, gnt_any, wr_fire;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [DATA_W-1:0]  gnt_data;

  always_comb begin
    fifo_empty = (level_q == '0);
    push       = usart_valid && ready_q;
    core_gnt   = 1'b0;
    usart_gnt  = 1'b0;
    if (state_q == S_NORMAL) begin
      core_gnt  = core_wr_req;
      usart_gnt = !core_wr_req && !fifo_empty;
    end else begin
      usart_gnt = !fifo_empty;
    end
    pop      = usart_gnt;
    gnt_any  = core_gnt || usart_gnt;
    gnt_addr = core_gnt ? core_wr_addr : mem_addr_q[rd_ptr_q];
    gnt_data = core_gnt ? core_wr_data : mem_data_q[rd_ptr_q];

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    starve_d = starve_q;
    if (usart_gnt || fifo_empty)
      starve_d = '0;
    else if (core_gnt && (starve_q != CNT_MAX))
      starve_d = starve_q + CNT_W'(1);

    // FORCE lasts exactly one cycle: the FIFO is never empty on entry.
    state_d = S_NORMAL;
    if (state_q == S_NORMAL && core_gnt && !fifo_empty && starve_q == CNT_TRIG)
      state_d = S_FORCE;
  end

`ifdef REGFILE_ARB_ZERO_PROTECT_EN
  assign wr_fire = gnt_any && (gnt_addr != '0);
`else
  assign wr_fire = gnt_any;
`endif

  assign core_stall  = core_wr_req && (state_q == S_FORCE);
  assign usart_ready = ready_q;
  assign overflow    = overflow_q;
  assign fifo_level  = level_q;
  assign rf_wr_en    = rf_en_q;
  assign rf_wr_addr  = rf_addr_q;
  assign rf_wr_data  = rf_data_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= usart_addr;
      mem_data_q[wr_ptr_q] <= usart_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_NORMAL;
      starve_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
      rf_en_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      level_q  <= level_d;
      ready_q  <= (level_d != FULL_LVL);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (usart_valid && !ready_q) overflow_q <= 1'b1;
      rf_en_q <= wr_fire;
      if (wr_fire) begin
        rf_addr_q <= gnt_addr;
        rf_data_q <= gnt_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter; honours REGFILE_ARB_ZERO_PROTECT_EN.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_wr_req = 1'b0;
  logic [4:0]  core_wr_addr = '0;
  logic [31:0] core_wr_data = '0;
  logic        core_stall;
  logic        usart_valid = 1'b0;
  logic [4:0]  usart_addr = '0;
  logic [31:0] usart_data = '0;
  logic        usart_ready;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [2:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic [4:0]  log_a [$];
  logic [31:0] log_d [$];
  int          log_c [$];

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .core_wr_req(core_wr_req), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_stall(core_stall),
    .usart_valid(usart_valid), .usart_addr(usart_addr), .usart_data(usart_data),
    .usart_ready(usart_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor: one entry per strobed cycle.
  always @(negedge clk) begin
    if (rf_wr_en === 1'b1) begin
      log_a.push_back(rf_wr_addr);
      log_d.push_back(rf_wr_data);
      log_c.push_back(cyc);
    end
  end

  task automatic idle_inputs();
    core_wr_req = 1'b0; core_wr_addr = '0; core_wr_data = '0;
    usart_valid = 1'b0; usart_addr = '0; usart_data = '0;
  endtask

  task automatic log_clear();
    log_a.delete(); log_d.delete(); log_c.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      core_wr_req = 1'($urandom); core_wr_addr = 5'($urandom); core_wr_data = $urandom;
      usart_valid = 1'($urandom); usart_addr = 5'($urandom); usart_data = $urandom;
      @(negedge clk);
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== 38'd0)
        $display("FAIL reset_rf: got en=%b addr=%0d data=%h, want 0/0/0", rf_wr_en, rf_wr_addr, rf_wr_data);
      else passes++;
      checks++;
      if (fifo_level !== 3'd0 || usart_ready !== 1'b1 || overflow !== 1'b0)
        $display("FAIL reset_fifo: got level=%0d ready=%b ovf=%b, want 0/1/0", fifo_level, usart_ready, overflow);
      else passes++;
    end
    idle_inputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rf_wr_en !== 1'b0) $display("FAIL reset_release_en: got %b want 0", rf_wr_en);
    else passes++;
  endtask

  task automatic test_core_only();
    core_wr_req = 1'b1; core_wr_addr = 5'd7; core_wr_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (core_stall !== 1'b0) $display("FAIL core_stall: got %b want 0", core_stall);
    else passes++;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'hDEADBEEF)
      $display("FAIL core_write: got en=%b addr=%0d data=%h, want 1/7/deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data);
    else passes++;
    @(negedge clk);
    checks++;
    if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'hDEADBEEF)
      $display("FAIL core_hold: got en=%b addr=%0d data=%h, want 0/7/deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data);
    else passes++;
  endtask

  task automatic test_usart_only();
    usart_valid = 1'b1; usart_addr = 5'd3; usart_data = 32'h55;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (fifo_level !== 3'd1 || rf_wr_en !== 1'b0)
      $display("FAIL usart_push: got level=%0d en=%b, want 1/0", fifo_level, rf_wr_en);
    else passes++;
    @(negedge clk);
    checks++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd3 || rf_wr_data !== 32'h55 || fifo_level !== 3'd0)
      $display("FAIL usart_write: got en=%b addr=%0d data=%h level=%0d, want 1/3/55/0",
               rf_wr_en, rf_wr_addr, rf_wr_data, fifo_level);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    log_clear();
    for (int i = 0; i < 3; i++) begin
      usart_valid = 1'b1; usart_addr = 5'(16 + i); usart_data = 32'h0B00 + 32'(i);
      @(negedge clk);
    end
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if (log_a.size() !== 3) $display("FAIL b2b_count: got %0d writes want 3", log_a.size());
    else passes++;
    for (int i = 0; i < 3; i++) begin
      if (i < log_a.size()) begin
        checks++;
        if (log_a[i] !== 5'(16 + i) || log_d[i] !== 32'h0B00 + 32'(i))
          $display("FAIL b2b_word%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   i, log_a[i], log_d[i], 16 + i, 32'h0B00 + 32'(i));
        else passes++;
        if (i > 0) begin
          checks++;
          if (log_c[i] !== log_c[i-1] + 1)
            $display("FAIL b2b_gap%0d: got cycle %0d want %0d", i, log_c[i], log_c[i-1] + 1);
          else passes++;
        end
      end
    end
  endtask

  task automatic test_starvation();
    logic [4:0] ca [6] = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd8};
    logic       uv [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       se [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] ea [6] = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd9, 5'd8};
    logic [31:0] ed;
    log_clear();
    for (int i = 0; i < 6; i++) begin
      core_wr_req = 1'b1; core_wr_addr = ca[i]; core_wr_data = 32'hC000_0000 + 32'(ca[i]);
      usart_valid = uv[i]; usart_addr = 5'd9; usart_data = 32'hA9;
      #1;
      checks++;
      if (core_stall !== se[i]) $display("FAIL starve_stall%0d: got %b want %b", i, core_stall, se[i]);
      else passes++;
      @(negedge clk);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (log_a.size() !== 6) $display("FAIL starve_count: got %0d writes want 6", log_a.size());
    else passes++;
    for (int i = 0; i < 6; i++) begin
      ed = (ea[i] == 5'd9) ? 32'hA9 : 32'hC000_0000 + 32'(ea[i]);
      if (i < log_a.size()) begin
        checks++;
        if (log_a[i] !== ea[i] || log_d[i] !== ed)
          $display("FAIL starve_word%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   i, log_a[i], log_d[i], ea[i], ed);
        else passes++;
      end
    end
  endtask

  task automatic test_zero_protect();
    core_wr_req = 1'b1; core_wr_addr = 5'd0; core_wr_data = 32'h1234;
    #1;
    checks++;
    if (core_stall !== 1'b0) $display("FAIL zero_stall: got %b want 0", core_stall);
    else passes++;
    @(negedge clk);
    idle_inputs();
`ifdef REGFILE_ARB_ZERO_PROTECT_EN
    checks++;
    if (rf_wr_en !== 1'b0) $display("FAIL zero_protect: got en=%b want 0", rf_wr_en);
    else passes++;
`else
    checks++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd0 || rf_wr_data !== 32'h1234)
      $display("FAIL zero_write: got en=%b addr=%0d data=%h want 1/0/1234", rf_wr_en, rf_wr_addr, rf_wr_data);
    else passes++;
`endif
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [4:0] ka [9] = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd15, 5'd0, 5'd0, 5'd0};
    logic       kr [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       uv [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       se [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [4:0] ea [9] = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd20, 5'd15, 5'd21, 5'd22, 5'd23};
    logic [31:0] ed;
    log_clear();
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        checks++;
        if (fifo_level !== 3'd4 || usart_ready !== 1'b0 || overflow !== 1'b0)
          $display("FAIL ovf_full: got level=%0d ready=%b ovf=%b want 4/0/0", fifo_level, usart_ready, overflow);
        else passes++;
      end
      if (i == 5) begin
        checks++;
        if (overflow !== 1'b1 || fifo_level !== 3'd3 || usart_ready !== 1'b1)
          $display("FAIL ovf_set: got ovf=%b level=%0d ready=%b want 1/3/1", overflow, fifo_level, usart_ready);
        else passes++;
      end
      core_wr_req = kr[i]; core_wr_addr = ka[i]; core_wr_data = 32'hD000_0000 + 32'(ka[i]);
      usart_valid = uv[i]; usart_addr = 5'(20 + i); usart_data = 32'h5500 + 32'(20 + i);
      #1;
      checks++;
      if (core_stall !== se[i]) $display("FAIL ovf_stall%0d: got %b want %b", i, core_stall, se[i]);
      else passes++;
      @(negedge clk);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0 || overflow !== 1'b1)
      $display("FAIL ovf_end: got level=%0d ovf=%b want 0/1", fifo_level, overflow);
    else passes++;
    checks++;
    if (log_a.size() !== 9) $display("FAIL ovf_count: got %0d writes want 9", log_a.size());
    else passes++;
    for (int i = 0; i < 9; i++) begin
      ed = (ea[i] >= 5'd20) ? 32'h5500 + 32'(ea[i]) : 32'hD000_0000 + 32'(ea[i]);
      if (i < log_a.size()) begin
        checks++;
        if (log_a[i] !== ea[i] || log_d[i] !== ed)
          $display("FAIL ovf_word%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   i, log_a[i], log_d[i], ea[i], ed);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_midop();
    usart_valid = 1'b1; usart_addr = 5'd30; usart_data = 32'h77;
    core_wr_req = 1'b1; core_wr_addr = 5'd5; core_wr_data = 32'h99;
    @(negedge clk);
    idle_inputs();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_level !== 3'd0 || usart_ready !== 1'b1 || overflow !== 1'b0 || rf_wr_en !== 1'b0)
      $display("FAIL midreset: got level=%0d ready=%b ovf=%b en=%b want 0/1/0/0",
               fifo_level, usart_ready, overflow, rf_wr_en);
    else passes++;
    repeat (2) @(negedge clk);
    log_clear();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (log_a.size() !== 0) $display("FAIL midreset_nowrite: got %0d writes want 0", log_a.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_core_only();
    test_usart_only();
    test_back_to_back();
    test_starvation();
    test_zero_protect();
    test_overflow();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
